// File: rtl/mont_mul_rk_pkg.sv
// Shared definitions for the radix-2^K Montgomery multiplier: FSM state
// encodings, LSU base-select codes and the digit-count helper.
package mont_mul_defines;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OPS = 3'd1,
        ST_FETCH_A   = 3'd2,
        ST_RUN       = 3'd3,
        ST_CORR      = 3'd4,
        ST_WRITE     = 3'd5
    } state_e;

    localparam logic [1:0] SEL_B     = 2'd0;
    localparam logic [1:0] SEL_N     = 2'd1;
    localparam logic [1:0] SEL_A     = 2'd2;
    localparam logic [1:0] SEL_RES   = 2'd3;
    localparam logic [1:0] DATA_WORD = 2'd2;

    // Number of RUN cycles needed to consume all of A for a given length.
    function automatic int digit_count(input int words, input int k);
        return (32 * words) / k;
    endfunction

endpackage

// File: rtl/mont_mul_rk_if.sv
// LSU-side bus of the Montgomery multiplier: word-serial read/write
// requests with a one-cycle completion strobe per word.
interface mont_mul_rk_if;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_addr_offset;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic [31:0] lsu_wdata;
    logic [1:0]  op_address_sel;

    modport master (
        output lsu_ren, lsu_wen, lsu_type, lsu_addr_offset, lsu_wdata, op_address_sel,
        input  lsu_done, lsu_rdata
    );

    modport slave (
        input  lsu_ren, lsu_wen, lsu_type, lsu_addr_offset, lsu_wdata, op_address_sel,
        output lsu_done, lsu_rdata
    );
endinterface

// File: rtl/mont_mul_rk_digit_step.sv
// One radix-2^K Montgomery digit: t = M + a*B, q = t*n0_inv mod 2^K,
// M' = (t + q*N) >> K. Purely combinational so it can be reused.
module mont_digit_step #(
    parameter int K = 2,
    parameter int W = 128
) (
    input  logic [W:0]   m_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] n_i,
    input  logic [K-1:0] a_i,
    input  logic [K-1:0] n0_inv_i,
    output logic [W:0]   m_o
);
    // Wide enough for M < 2N plus a*B plus q*N without any overflow.
    localparam int AW = W + K + 2;

    logic [AW-1:0] t_s;
    logic [AW-1:0] u_s;
    logic [K-1:0]  q_s;

    // Partial sum with the current digit of A.
    always_comb begin
        t_s = AW'(m_i) + AW'(a_i) * AW'(b_i);
    end

    if (K == 1) begin : g_q_bit
        // For a single-bit digit -N^-1 mod 2 is always 1.
        assign q_s = t_s[0];
    end else begin : g_q_mul
        assign q_s = K'(t_s[K-1:0] * n0_inv_i);
    end

    // Add the reduction multiple and drop the K low zero bits.
    always_comb begin
        u_s = t_s + AW'(q_s) * AW'(n_i);
        m_o = (W+1)'(u_s >> K);
    end
endmodule

// File: rtl/mont_mul_rk.sv
// Radix-2^K runtime-length Montgomery multiplier: result = A*B*R^-1 mod N,
// R = 2^(32*len). Operands are fetched word-serially over the LSU bus.
// Optional macro MONT_MUL_RK_FINAL_SUB_EN adds the final conditional
// subtraction (fully reduced result); without it the result is in [0, 2N).
module mont_mul_rk
    import mont_mul_defines::*;
#(
    parameter int MAX_WORDS    = 4,
    parameter int K            = 2,
    parameter int PARTIAL_EXEC = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(MAX_WORDS):0]     len,
    input  logic [K-1:0]                   n0_inv,
    mont_mul_rk_if.master                  lsu,
    output logic [32*MAX_WORDS-1:0]        result,
    output logic                           done
);
    localparam int W    = 32 * MAX_WORDS;
    localparam int LW   = $clog2(MAX_WORDS) + 1;
    localparam int IW   = LW + 1;
    localparam int LDPW = $clog2(32 / K);
    localparam int DW   = $clog2(32 * MAX_WORDS / K) + 1;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [K-1:0]  n0_q, n0_d;
    logic [W:0]    m_q, m_d;
    logic [W-1:0]  b_q, b_d, n_q, n_d;
    logic [31:0]   a_q, a_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] dig_q, dig_d;
    logic          ren_q, ren_d, wen_q, wen_d, done_q, done_d;
    logic [1:0]    sel_q, sel_d;
    logic [31:0]   off_q, off_d, wdata_q, wdata_d;
    logic [LW-2:0] nw_s, nw_d_s;
    logic [W:0]    m_step_s;
`ifdef MONT_MUL_RK_FINAL_SUB_EN
    logic [W+1:0]  diff_s;
`endif

    mont_digit_step #(.K(K), .W(W)) u_step (
        .m_i      (m_q),
        .b_i      (b_q),
        .n_i      (n_q),
        .a_i      (a_q[K-1:0]),
        .n0_inv_i (n0_q),
        .m_o      (m_step_s)
    );

`ifdef MONT_MUL_RK_FINAL_SUB_EN
    // Single shared subtractor; the top bit is the borrow (M < N).
    always_comb begin
        diff_s = {1'b0, m_q} - {2'b00, n_q};
    end
`endif

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        n0_d    = n0_q;
        m_d     = m_q;
        b_d     = b_q;
        n_d     = n_q;
        a_d     = a_q;
        idx_d   = idx_q;
        dig_d   = dig_q;
        done_d  = 1'b0;
        // N word index during the second half of operand fetch (idx - L).
        nw_s    = idx_q[LW-2:0] - len_q[LW-2:0];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH_OPS;
                    if ((len == '0) || (int'(len) > MAX_WORDS)) begin
                        len_d = LW'(MAX_WORDS);
                    end else begin
                        len_d = len;
                    end
                    n0_d  = n0_inv;
                    m_d   = '0;
                    b_d   = '0;
                    n_d   = '0;
                    a_d   = '0;
                    idx_d = '0;
                    dig_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH_OPS: begin
                if (lsu.lsu_done) begin
                    if (idx_q < IW'(len_q)) begin
                        b_d[32*int'(idx_q[LW-2:0]) +: 32] = lsu.lsu_rdata;
                    end else begin
                        n_d[32*int'(nw_s) +: 32] = lsu.lsu_rdata;
                    end
                    if (idx_q == IW'(len_q) + IW'(len_q) - IW'(1)) begin
                        state_d = ST_FETCH_A;
                        idx_d   = '0;
                        dig_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_FETCH_OPS;
                end
            end
            ST_FETCH_A: begin
                if (lsu.lsu_done) begin
                    a_d     = lsu.lsu_rdata;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FETCH_A;
                end
            end
            ST_RUN: begin
                if ((PARTIAL_EXEC == 0) || start) begin
                    m_d    = m_step_s;
                    a_d    = a_q >> K;
                    dig_d  = dig_q + DW'(1);
                    done_d = (PARTIAL_EXEC != 0);
                    if (int'(dig_d) == digit_count(int'(len_q), K)) begin
`ifdef MONT_MUL_RK_FINAL_SUB_EN
                        state_d = ST_CORR;
`else
                        state_d = ST_WRITE;
                        idx_d   = '0;
`endif
                    end else if (dig_d[LDPW-1:0] == '0) begin
                        state_d = ST_FETCH_A;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CORR: begin
`ifdef MONT_MUL_RK_FINAL_SUB_EN
                if (!diff_s[W+1]) begin
                    m_d = diff_s[W:0];
                end else begin
                    m_d = m_q;
                end
                state_d = ST_WRITE;
                idx_d   = '0;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_WRITE: begin
                if (lsu.lsu_done) begin
                    if (idx_q == IW'(len_q) - IW'(1)) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus outputs are decoded from the next state so they leave flops.
        nw_d_s  = idx_d[LW-2:0] - len_d[LW-2:0];
        ren_d   = (state_d == ST_FETCH_OPS) || (state_d == ST_FETCH_A);
        wen_d   = (state_d == ST_WRITE);
        sel_d   = SEL_A;
        off_d   = 32'd0;
        wdata_d = 32'd0;
        case (state_d)
            ST_FETCH_OPS: begin
                if (idx_d < IW'(len_d)) begin
                    sel_d = SEL_B;
                    off_d = 32'(idx_d) * 32'd4;
                end else begin
                    sel_d = SEL_N;
                    off_d = 32'(nw_d_s) * 32'd4;
                end
            end
            ST_FETCH_A: begin
                sel_d = SEL_A;
                off_d = 32'(dig_d >> LDPW) * 32'd4;
            end
            ST_WRITE: begin
                sel_d   = SEL_RES;
                off_d   = 32'(idx_d) * 32'd4;
                wdata_d = m_d[32*int'(idx_d[LW-2:0]) +: 32];
            end
            default: begin
                sel_d = SEL_A;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            n0_q    <= '0;
            m_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            a_q     <= 32'd0;
            idx_q   <= '0;
            dig_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            sel_q   <= SEL_A;
            off_q   <= 32'd0;
            wdata_q <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            n0_q    <= n0_d;
            m_q     <= m_d;
            b_q     <= b_d;
            n_q     <= n_d;
            a_q     <= a_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign lsu.lsu_ren         = ren_q;
    assign lsu.lsu_wen         = wen_q;
    assign lsu.lsu_type        = DATA_WORD;
    assign lsu.lsu_addr_offset = off_q;
    assign lsu.lsu_wdata       = wdata_q;
    assign lsu.op_address_sel  = sel_q;
    assign result              = m_q[W-1:0];
    assign done                = done_q;
endmodule

// File: tb/tb_mont_mul_rk.sv
// Directed-vector bench for mont_mul_rk (MAX_WORDS=4, K=2) with an LSU
// memory model that inserts wait states and audits every access.
module tb_mont_mul_rk;
    import mont_mul_defines::*;

    localparam int MAXW = 4;

    typedef struct {
        logic [2:0]   len;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] n;
        logic [127:0] exp;
        int           max_wait;
        bit           chk_lat;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   len_in;
    logic [1:0]   n0_in;
    logic [127:0] result;
    logic         done;

    mont_mul_rk_if lsu_if ();

    mont_mul_rk #(.MAX_WORDS(MAXW), .K(2), .PARTIAL_EXEC(0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .len    (len_in),
        .n0_inv (n0_in),
        .lsu    (lsu_if),
        .result (result),
        .done   (done)
    );

    int n_applied = 0;
    int n_bad     = 0;

    logic [31:0] mem_b [MAXW];
    logic [31:0] mem_n [MAXW];
    logic [31:0] mem_a [MAXW];
    logic [31:0] mem_r [MAXW];
    int reads_b, reads_n, reads_a, writes, viol, hold_viol, done_cnt;
    int cur_leff = MAXW;
    int max_wait = 0;
    int wcnt     = 0;
    bit busy     = 0;
    logic [1:0]  h_sel;
    logic [31:0] h_off, h_wd;
    logic        h_wen;

`ifdef MONT_MUL_RK_FINAL_SUB_EN
    localparam int LAT = 82;
    localparam logic [127:0] EXP_NM1 = 128'h0CCCCCCC9;
`else
    localparam int LAT = 81;
    localparam logic [127:0] EXP_NM1 = 128'h1CCCCCCC4;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // LSU model: random wait, one-cycle done, request-hold and range audit.
    always @(negedge clk) begin
        if (!rst_n) begin
            lsu_if.lsu_done = 1'b0;
            busy = 0;
        end else if (lsu_if.lsu_ren || lsu_if.lsu_wen) begin
            if (lsu_if.lsu_ren && lsu_if.lsu_wen) viol++;
            if (!busy) begin
                busy  = 1;
                wcnt  = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
                h_sel = lsu_if.op_address_sel;
                h_off = lsu_if.lsu_addr_offset;
                h_wen = lsu_if.lsu_wen;
                h_wd  = lsu_if.lsu_wdata;
            end else if (h_sel !== lsu_if.op_address_sel || h_off !== lsu_if.lsu_addr_offset ||
                         h_wen !== lsu_if.lsu_wen || h_wd !== lsu_if.lsu_wdata) begin
                hold_viol++;
            end
            if (wcnt == 0) begin
                logic [29:0] w;
                w = lsu_if.lsu_addr_offset[31:2];
                if (int'(w) >= cur_leff || lsu_if.lsu_addr_offset[1:0] != 2'd0) viol++;
                if (lsu_if.lsu_wen) begin
                    if (lsu_if.op_address_sel != 2'd3) viol++;
                    writes++;
                    if (int'(w) < MAXW) mem_r[w[1:0]] = lsu_if.lsu_wdata;
                end else begin
                    case (lsu_if.op_address_sel)
                        2'd0: begin reads_b++; lsu_if.lsu_rdata = mem_b[w[1:0]]; end
                        2'd1: begin reads_n++; lsu_if.lsu_rdata = mem_n[w[1:0]]; end
                        2'd2: begin reads_a++; lsu_if.lsu_rdata = mem_a[w[1:0]]; end
                        default: viol++;
                    endcase
                end
                lsu_if.lsu_done = 1'b1;
                busy = 0;
            end else begin
                wcnt--;
                lsu_if.lsu_done = 1'b0;
            end
        end else begin
            lsu_if.lsu_done = 1'b0;
            busy = 0;
        end
    end

    // Count completion pulses.
    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
    end

    function automatic logic [127:0] mask_of(input int l);
        return (l >= 4) ? {128{1'b1}} : ((128'd1 << (32 * l)) - 128'd1);
    endfunction

    // Independent model: Q = -(A*B)*N^-1 mod R, M = (A*B + Q*N)/R.
    function automatic logic [127:0] ref_mont(input logic [127:0] a, b, n, input int l);
        logic [127:0] mask, inv, p, q;
        logic [255:0] ab, s;
        mask = mask_of(l);
        inv  = n;
        for (int i = 0; i < 7; i++) inv = inv * (128'd2 - n * inv);
        ab = {128'd0, a} * {128'd0, b};
        p  = (ab[127:0] * inv) & mask;
        q  = ((~p) + 128'd1) & mask;
        s  = (ab + {128'd0, q} * {128'd0, n}) >> (32 * l);
`ifdef MONT_MUL_RK_FINAL_SUB_EN
        if (s >= {128'd0, n}) s = s - {128'd0, n};
`endif
        return s[127:0];
    endfunction

    task automatic start_op(input vec_t v);
        for (int i = 0; i < MAXW; i++) begin
            mem_b[i] = v.b[32*i +: 32];
            mem_n[i] = v.n[32*i +: 32];
            mem_a[i] = v.a[32*i +: 32];
            mem_r[i] = 32'h0BAD_0BAD;
        end
        cur_leff = (v.len == 3'd0 || int'(v.len) > MAXW) ? MAXW : int'(v.len);
        max_wait = v.max_wait;
        reads_b = 0; reads_n = 0; reads_a = 0; writes = 0;
        viol = 0; hold_viol = 0; done_cnt = 0;
        len_in = v.len;
        n0_in  = (~v.n[1:0]) + 2'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int cyc;
        start_op(v);
        cyc = 1;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        n_applied++;
        chk({tag, " done_seen"}, 128'(cyc < 4000), 128'd1);
        chk({tag, " result"}, result, v.exp);
        for (int i = 0; i < cur_leff; i++)
            chk({tag, " wword"}, 128'(mem_r[i]), 128'(v.exp[32*i +: 32]));
        chk({tag, " reads_b"}, 128'(reads_b), 128'(cur_leff));
        chk({tag, " reads_n"}, 128'(reads_n), 128'(cur_leff));
        chk({tag, " reads_a"}, 128'(reads_a), 128'(cur_leff));
        chk({tag, " writes"}, 128'(writes), 128'(cur_leff));
        chk({tag, " bad_access"}, 128'(viol), 128'd0);
        chk({tag, " req_hold"}, 128'(hold_viol), 128'd0);
        chk({tag, " done_pulses"}, 128'(done_cnt), 128'd1);
        if (v.chk_lat) chk({tag, " latency"}, 128'(cyc), 128'(LAT));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ren"}, 128'(lsu_if.lsu_ren), 128'd0);
        chk({tag, " wen"}, 128'(lsu_if.lsu_wen), 128'd0);
        chk({tag, " sel"}, 128'(lsu_if.op_address_sel), 128'd2);
        chk({tag, " type"}, 128'(lsu_if.lsu_type), 128'(DATA_WORD));
        chk({tag, " offset"}, 128'(lsu_if.lsu_addr_offset), 128'd0);
        chk({tag, " wdata"}, 128'(lsu_if.lsu_wdata), 128'd0);
        chk({tag, " result"}, result, 128'd0);
        chk({tag, " done"}, 128'(done), 128'd0);
    endtask

    function automatic vec_t rnd_vec(input int l, input int mw);
        vec_t v;
        logic [127:0] m;
        m = mask_of(l);
        v.len = 3'(l);
        v.n = ({$urandom, $urandom, $urandom, $urandom} & m) | 128'd1 | (128'd1 << (32 * l - 1));
        v.b = {$urandom, $urandom, $urandom, $urandom} & m;
        if (v.b >= v.n) v.b = v.b - v.n;
        v.a = {$urandom, $urandom, $urandom, $urandom} & m;
        v.exp = ref_mont(v.a, v.b, v.n, l);
        v.max_wait = mw;
        v.chk_lat = 1'b0;
        return v;
    endfunction

    vec_t vt [6];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        len_in = 3'd0;
        n0_in = 2'd0;
        lsu_if.lsu_done = 1'b0;
        lsu_if.lsu_rdata = 32'd0;
        for (int i = 0; i < MAXW; i++) mem_r[i] = 32'd0;

        vt[0] = '{3'd1, 128'd3, 128'd5, 128'd7, 128'd2, 0, 1'b0};
        vt[1] = '{3'd0, 128'd0, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                  128'h8000_0000_0000_0000_0000_0000_0000_0001, 128'd0, 0, 1'b1};
        vt[2] = '{3'd1, 128'd1, 128'd1, 128'd3, 128'd1, 0, 1'b0};
        vt[3] = '{3'd1, 128'hFFFF_FFFA, 128'hFFFF_FFFA, 128'hFFFF_FFFB, EXP_NM1, 0, 1'b0};
        vt[4] = '{3'd5, 128'd0, 128'h7777_0000_1111_2222, 128'hFFFF_0000_0000_0000_0000_0000_0000_0003,
                  128'd0, 3, 1'b0};
        vt[5] = '{3'd2, 128'd1, 128'd1, 128'd3, 128'd1, 5, 1'b0};

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

        // Abort in the middle of RUN, then a clean operation.
        start_op(rnd_vec(4, 0));
        repeat (18) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun no_write", 128'(writes), 128'd0);
        @(negedge clk);
        apply_vec(rnd_vec(4, 0), "after_rst");

        for (int i = 0; i < 300; i++) apply_vec(rnd_vec(2, 0), "rnd_l2");
        for (int i = 0; i < 40; i++) apply_vec(rnd_vec(1 + (i % 4), 5), "rnd_wait");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
        $finish;
    end
endmodule

// File: doc/mont_mul_rk.md
Name: mont_mul_rk

Overview:
- Radix-2^K, runtime-length Montgomery multiplier; next generation of the co-processor's mont_mul unit.
- Computes result = A*B*R^-1 mod N, with R = 2^(32*len).
- Fetches operands word-serially over the same LSU handshake.
- Retires K bits of A per cycle, then writes the result back to memory.
- Sits beside the RISC-V core's LSU. The core supplies base addresses through op_address_sel.

Parameters:
- MAX_WORDS, 4: maximum operand length in 32-bit words; power of two, >=2.
- K, 2: digit width in bits; one of 1, 2, 4, 8. Each A word takes 32/K RUN cycles.
- PARTIAL_EXEC, 0: 1 = RUN advances only while start is high, and done pulses after each digit (matches the core's stepped mode).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin operation (sampled in IDLE); run-enable when PARTIAL_EXEC=1
- len  in  $clog2(MAX_WORDS)+1  operand length in words, sampled with start
- n0_inv  in  K  (-N^-1) mod 2^K, sampled with start; ignored when K=1
- lsu_ren  out  1  read request
- lsu_wen  out  1  write request
- lsu_type  out  2  constant DATA_WORD
- lsu_addr_offset  out  32  byte offset from the selected base
- lsu_done  in  1  LSU completion, one cycle per word
- lsu_rdata  in  32  read data
- lsu_wdata  out  32  write data
- op_address_sel  out  2  base select: 0=B, 1=N, 2=A, 3=result
- result  out  32*MAX_WORDS  M[32*MAX_WORDS-1:0]
- done  out  1  completion pulse

Behaviour:
- Reset:
  - state IDLE; M, B, N, A word, counters, latched len/n0_inv = 0.
  - All outputs 0, except op_address_sel=2 and lsu_type=DATA_WORD.
- len handling:
  - Latched as L on start.
  - L=0 or L>MAX_WORDS is treated as MAX_WORDS.
  - B/N words >= L are zeroed on start.
- IDLE -> FETCH_OPS on start. M is cleared.
- FETCH_OPS:
  - lsu_ren=1; reads B[0..L-1] (sel 0), then N[0..L-1] (sel 1).
  - offset = word index * 4.
  - Each lsu_done latches one word and advances the index.
  - After the last N word -> FETCH_A with digit counter = 0.
  - Request stays asserted across LSU wait cycles.
- FETCH_A:
  - lsu_ren=1, sel 2, offset = (digit counter / (32/K)) * 4.
  - lsu_done latches the A word -> RUN.
- RUN (one cycle per digit), with a = A[K-1:0]:
  - t = M + a*B
  - q = (t[K-1:0]*n0_inv) mod 2^K; for K=1, q = t[0]
  - M <= (t + q*N) >> K
  - A >>= K; counter++
- RUN exit:
  - After 32*L/K digits -> CORR.
  - Else, when the counter reaches an A-word boundary -> FETCH_A.
  - Else stay in RUN.
- Widths:
  - M is 32*MAX_WORDS+1 bits; the invariant M < 2N holds given B < N.
  - The datapath adder is 32*MAX_WORDS+K+2 bits; no truncation is permitted.
- CORR (one cycle): if M >= N then M <= M - N, using a single shared subtractor. -> WRITE.
- WRITE:
  - lsu_wen=1, sel 3, offset = i*4, wdata = result word i.
  - i advances on lsu_done.
  - After word L-1: done=1 for one cycle -> IDLE.
- start while busy is ignored (except as the run-enable when PARTIAL_EXEC=1).
- Asynchronous reset mid-operation aborts with no write; the next start begins cleanly.
- lsu_ren and lsu_wen are never asserted together.
- Latency for K=2, L=4, zero-wait LSU: 8 + 4*(1+16) + 1 + 4 + 1 ≈ 82 cycles.

Optional Feature:
- Macro MONT_MUL_RK_FINAL_SUB_EN.
- Defined: CORR state present; result is fully reduced (< N).
- Undefined: CORR removed; RUN -> WRITE directly. Result is in the redundant range [0, 2N), which is valid as input to chained multiplies. Saves one cycle and the subtractor.

Decomposition:
- Shared package mont_mul_defines: state encodings, op_address_sel codes (SEL_B, SEL_N, SEL_A, SEL_RES), and the digit-count function.
- One natural sub-module, mont_digit_step: the combinational t/q/M_n digit datapath, parametrised on K and width. It is reusable by a future exponentiator.

Test Plan:
- K=2, L=1, B=5, N=7, A=3, n0_inv=1 -> written word 2; done one pulse; exactly 2 reads of B/N, 1 read of A, 1 write.
- K=1, L=4, A=0, random B, N odd -> result 0, and all 4 words are written.
- L=0 with MAX_WORDS=4 -> behaves as L=4. L=2 -> only offsets 0 and 4 are accessed per operand; results match a reference model over 1000 random odd N.
- Random LSU wait states of 0-5 cycles on every access -> same result. Requests are held until lsu_done; no extra access occurs.
- Case A=B=N-1 with N=0xFFFFFFFB, L=1:
  - With FINAL_SUB_EN: result < N.
  - Without it: result < 2N and congruent mod N.
- rst_n pulsed low during RUN -> all outputs at reset values immediately. A subsequent start with new operands produces the correct result.
